node_exec: RTL and testbench

NODE_EXEC -- requirements
Module: node_exec

---
 rtl/tis_pkg.sv | 63 ++++++
 rtl/tis_alu.sv | 47 ++++
 rtl/node_exec.sv | 161 ++++++++++++++++
 tb/tb_node_exec.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
// Shared types and constants for the node execution core: instruction field
// positions, opcode/src/dst encodings, ALU ops, FSM states and data limits.
package tis_pkg;

  localparam int DATA_W  = 11;
  localparam int INSTR_W = 21;
  localparam int VAL_MAX = 999;

  localparam int OP_MSB  = 20;
  localparam int OP_LSB  = 17;
  localparam int SRC_MSB = 16;
  localparam int SRC_LSB = 14;
  localparam int DST_MSB = 13;
  localparam int DST_LSB = 11;
  localparam int IMM_MSB = 10;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_SWP = 4'd2,
    OP_SAV = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_NEG = 4'd6,
    OP_JMP = 4'd7,
    OP_JEZ = 4'd8,
    OP_JNZ = 4'd9,
    OP_JGZ = 4'd10,
    OP_JLZ = 4'd11,
    OP_JRO = 4'd12
  } opcode_e;

  typedef enum logic [2:0] {
    SRC_IMM = 3'd0,
    SRC_ACC = 3'd1,
    SRC_NIL = 3'd2,
    SRC_IN  = 3'd3
  } src_e;

  typedef enum logic [2:0] {
    DST_NIL = 3'd0,
    DST_ACC = 3'd1,
    DST_OUT = 3'd2
  } dst_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_NEG = 2'd2
  } alu_op_e;

  typedef enum logic {
    ST_EXEC     = 1'b0,
    ST_WAIT_OUT = 1'b1
  } state_e;

  // Only these opcodes actually consume their source operand (and so may touch IN).
  function automatic logic uses_src(input opcode_e opc);
    return (opc == OP_MOV) || (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_JRO);
  endfunction

endpackage

// File: rtl/tis_alu.sv
// Combinational add/sub/neg at DATA_W+1 bits; zero latency, no handshake.
// Result clamps to +/-VAL_MAX with NODE_EXEC_SATURATE_EN, otherwise wraps to DATA_W.
module tis_alu #(
  parameter int DATA_W = tis_pkg::DATA_W
) (
  input  tis_pkg::alu_op_e         alu_op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);
  import tis_pkg::*;

  logic signed [DATA_W:0] a_w;
  logic signed [DATA_W:0] b_w;
  logic signed [DATA_W:0] wide;

  assign a_w = {a[DATA_W-1], a};
  assign b_w = {b[DATA_W-1], b};

  always_comb begin
    wide = a_w + b_w;
    case (alu_op)
      ALU_SUB: wide = a_w - b_w;
      ALU_NEG: wide = -a_w;
      default: wide = a_w + b_w;
    endcase
  end

`ifdef NODE_EXEC_SATURATE_EN
  localparam logic signed [DATA_W:0] LIM = (DATA_W + 1)'(VAL_MAX);

  always_comb begin
    y = wide[DATA_W-1:0];
    if (wide > LIM) begin
      y = LIM[DATA_W-1:0];
    end else if (wide < -LIM) begin
      y = (-LIM) & {(DATA_W + 1){1'b1}};
    end
  end
`else
  logic unused_msb;

  assign unused_msb = wide[DATA_W];
  assign y          = wide[DATA_W-1:0];
`endif

endmodule

// File: rtl/node_exec.sv
// Single-node executor: one instruction per cycle, stalls on IN without data and holds
// in WAIT_OUT until OUT is taken. NODE_EXEC_SATURATE_EN clamps IN/IMM and arithmetic.
module node_exec #(
  parameter int INSTR_W = tis_pkg::INSTR_W,
  parameter int DATA_W  = tis_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic [DATA_W-1:0]  acc,
  output logic [DATA_W-1:0]  jmp_off,
  output logic               advance,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready
);
  import tis_pkg::*;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] bak_q, bak_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;

  opcode_e                  opc;
  src_e                     src_sel;
  dst_e                     dst_sel;
  logic signed [DATA_W-1:0] imm;
  logic signed [DATA_W-1:0] src_val;
  logic signed [DATA_W-1:0] alu_y;
  alu_op_e                  alu_op;
  logic                     reads_in;
  logic                     to_out;
  logic                     src_ok;

  assign opc     = opcode_e'(instr[OP_MSB:OP_LSB]);
  assign src_sel = src_e'(instr[SRC_MSB:SRC_LSB]);
  assign dst_sel = dst_e'(instr[DST_MSB:DST_LSB]);
  assign imm     = instr[IMM_MSB:IMM_LSB];

  function automatic logic signed [DATA_W-1:0] clamp_in(input logic signed [DATA_W-1:0] v);
`ifdef NODE_EXEC_SATURATE_EN
    logic signed [DATA_W-1:0] lim;
    lim = DATA_W'(VAL_MAX);
    if (v > lim) begin
      return lim;
    end else if (v < -lim) begin
      return -lim;
    end
    return v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    src_val = '0;
    case (src_sel)
      SRC_IMM: src_val = clamp_in(imm);
      SRC_ACC: src_val = acc_q;
      SRC_IN:  src_val = clamp_in(in_data);
      default: src_val = '0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    if (opc == OP_SUB) begin
      alu_op = ALU_SUB;
    end else if (opc == OP_NEG) begin
      alu_op = ALU_NEG;
    end
  end

  tis_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .alu_op (alu_op),
    .a      (acc_q),
    .b      (src_val),
    .y      (alu_y)
  );

  assign reads_in = uses_src(opc) && (src_sel == SRC_IN);
  assign to_out   = (opc == OP_MOV) && (dst_sel == DST_OUT);
  assign src_ok   = !reads_in || in_valid;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    bak_d       = bak_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    advance     = 1'b0;
    in_ready    = 1'b0;

    if (!reset && clk_en) begin
      case (state_q)
        ST_EXEC: begin
          in_ready = reads_in;
          if (src_ok) begin
            if (to_out) begin
              // The instruction retires only once the consumer takes the word.
              out_data_d  = src_val;
              out_valid_d = 1'b1;
              state_d     = ST_WAIT_OUT;
            end else begin
              advance = 1'b1;
              case (opc)
                OP_MOV: if (dst_sel == DST_ACC) acc_d = src_val;
                OP_SWP: begin
                  acc_d = bak_q;
                  bak_d = acc_q;
                end
                OP_SAV: bak_d = acc_q;
                OP_ADD, OP_SUB, OP_NEG: acc_d = alu_y;
                default: acc_d = acc_q;
              endcase
            end
          end
        end
        ST_WAIT_OUT: begin
          advance = out_ready;
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_EXEC;
          end
        end
        default: state_d = ST_EXEC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EXEC;
      acc_q       <= '0;
      bak_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bak_q       <= bak_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign op        = instr[OP_MSB:OP_LSB];
  assign acc       = acc_q;
  assign jmp_off   = src_val;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_node_exec.sv
// Directed self-checking bench for node_exec: reset, arithmetic, port handshakes,
// register moves, opcode/src/dst aliases, clock enable and reset during WAIT_OUT.
module tb_node_exec;

  localparam logic [3:0] NOP = 4'd0, MOV = 4'd1, SWP = 4'd2, SAV = 4'd3, ADD = 4'd4,
                         SUB = 4'd5, NEG = 4'd6, JRO = 4'd12;
  localparam logic [2:0] S_IMM = 3'd0, S_ACC = 3'd1, S_IN = 3'd3;
  localparam logic [2:0] D_NIL = 3'd0, D_ACC = 3'd1, D_OUT = 3'd2;

`ifdef NODE_EXEC_SATURATE_EN
  localparam int ADD_EXP = 999;
  localparam int SUB_EXP = -999;
  localparam int BIG_EXP = 999;
`else
  localparam int ADD_EXP = -948;
  localparam int SUB_EXP = 948;
  localparam int BIG_EXP = 1000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [20:0] instr;
  logic [3:0]  op;
  logic [10:0] acc;
  logic [10:0] jmp_off;
  logic        advance;
  logic [10:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  node_exec dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .instr     (instr),
    .op        (op),
    .acc       (acc),
    .jmp_off   (jmp_off),
    .advance   (advance),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [20:0] mk(input logic [3:0] o, input logic [2:0] s,
                                     input logic [2:0] d, input int imm);
    logic [10:0] i;
    i = 11'(imm);
    return {o, s, d, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    instr = mk(MOV, S_IMM, D_ACC, 5);
    tick();
    tick();
    checks++; if (acc !== 11'(0)) begin fails++; $display("FAIL reset_acc: got %0d want 0", $signed(acc)); end
    checks++; if (out_valid !== 1'b0 || out_data !== 11'(0)) begin fails++; $display("FAIL reset_out: valid=%b data=%0d want 0/0", out_valid, out_data); end
    checks++; if (advance !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL reset_hs: advance=%b in_ready=%b want 0/0", advance, in_ready); end
    checks++; if (op !== 4'd1 || jmp_off !== 11'(5)) begin fails++; $display("FAIL reset_passthru: op=%0d jmp_off=%0d want 1/5", op, jmp_off); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int       imms [3] = '{5, 7, 20};
    logic [3:0] ops [3] = '{MOV, ADD, SUB};
    int       exps [3] = '{5, 12, -8};
    for (int i = 0; i < 3; i++) begin
      instr = mk(ops[i], S_IMM, D_ACC, imms[i]);
      #1;
      checks++; if (advance !== 1'b1) begin fails++; $display("FAIL basic_adv%0d: got %b want 1", i, advance); end
      tick();
      checks++; if (acc !== 11'(exps[i])) begin fails++; $display("FAIL basic_acc%0d: got %0d want %0d", i, $signed(acc), exps[i]); end
    end
  endtask

  task automatic test_overflow();
    instr = mk(MOV, S_IMM, D_ACC, 900); tick();
    instr = mk(ADD, S_IMM, D_ACC, 200); tick();
    checks++; if (acc !== 11'(ADD_EXP)) begin fails++; $display("FAIL ovf_add: got %0d want %0d", $signed(acc), ADD_EXP); end
    instr = mk(MOV, S_IMM, D_ACC, -900); tick();
    instr = mk(SUB, S_IMM, D_ACC, 200); tick();
    checks++; if (acc !== 11'(SUB_EXP)) begin fails++; $display("FAIL ovf_sub: got %0d want %0d", $signed(acc), SUB_EXP); end
    instr = mk(MOV, S_IMM, D_ACC, 1000); tick();
    checks++; if (acc !== 11'(BIG_EXP)) begin fails++; $display("FAIL imm_big: got %0d want %0d", $signed(acc), BIG_EXP); end
  endtask

  task automatic test_in_stall();
    instr = mk(MOV, S_IMM, D_ACC, 1); tick();
    instr = mk(MOV, S_IN, D_ACC, 0);
    in_valid = 1'b0; in_data = 11'(7);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (advance !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL in_stall%0d: advance=%b in_ready=%b want 0/1", i, advance, in_ready); end
      tick();
      checks++; if (acc !== 11'(1)) begin fails++; $display("FAIL in_hold%0d: got %0d want 1", i, $signed(acc)); end
    end
    in_data = 11'(42); in_valid = 1'b1;
    #1;
    checks++; if (advance !== 1'b1) begin fails++; $display("FAIL in_adv: got %b want 1", advance); end
    tick();
    in_valid = 1'b0;
    checks++; if (acc !== 11'(42)) begin fails++; $display("FAIL in_acc: got %0d want 42", $signed(acc)); end
  endtask

  task automatic test_out();
    instr = mk(MOV, S_IMM, D_OUT, 17); out_ready = 1'b0;
    #1;
    checks++; if (advance !== 1'b0) begin fails++; $display("FAIL out_issue_adv: got %b want 0", advance); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 11'(17)) begin fails++; $display("FAIL out_load: valid=%b data=%0d want 1/17", out_valid, out_data); end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (advance !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL out_wait%0d: advance=%b in_ready=%b want 0/0", i, advance, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 11'(17)) begin fails++; $display("FAIL out_hold%0d: valid=%b data=%0d want 1/17", i, out_valid, out_data); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (advance !== 1'b1) begin fails++; $display("FAIL out_adv: got %b want 1", advance); end
    tick();
    instr = mk(NOP, S_IMM, D_NIL, 0); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || acc !== 11'(42)) begin fails++; $display("FAIL out_done: valid=%b acc=%0d want 0/42", out_valid, $signed(acc)); end
  endtask

  task automatic test_sav_neg_swp();
    instr = mk(MOV, S_IMM, D_ACC, 3); tick();
    instr = mk(SAV, S_IMM, D_NIL, 0); tick();
    instr = mk(NEG, S_IMM, D_NIL, 0); tick();
    checks++; if (acc !== 11'(-3)) begin fails++; $display("FAIL neg_acc: got %0d want -3", $signed(acc)); end
    instr = mk(SWP, S_IMM, D_NIL, 0); tick();
    checks++; if (acc !== 11'(3)) begin fails++; $display("FAIL swp_acc: got %0d want 3", $signed(acc)); end
    tick();
    checks++; if (acc !== 11'(-3)) begin fails++; $display("FAIL swp_bak: got %0d want -3", $signed(acc)); end
  endtask

  task automatic test_aliases();
    instr = mk(JRO, S_ACC, D_NIL, 0);
    #1;
    checks++; if (op !== 4'd12 || jmp_off !== 11'(-3) || advance !== 1'b1) begin fails++; $display("FAIL jro: op=%0d jmp_off=%0d advance=%b want 12/-3/1", op, $signed(jmp_off), advance); end
    tick();
    instr = mk(4'd14, S_IMM, D_ACC, 100); tick();
    checks++; if (acc !== 11'(-3)) begin fails++; $display("FAIL op14_nop: got %0d want -3", $signed(acc)); end
    instr = mk(MOV, 3'd5, D_ACC, 77); tick();
    checks++; if (acc !== 11'(0)) begin fails++; $display("FAIL src_alias_nil: got %0d want 0", $signed(acc)); end
    instr = mk(MOV, S_IMM, 3'd6, 55); tick();
    checks++; if (acc !== 11'(0) || out_valid !== 1'b0) begin fails++; $display("FAIL dst_alias_nil: acc=%0d valid=%b want 0/0", $signed(acc), out_valid); end
  endtask

  task automatic test_clk_en();
    instr = mk(MOV, S_IMM, D_ACC, 1); tick();
    clk_en = 1'b0;
    instr = mk(ADD, S_IMM, D_ACC, 5);
    #1;
    checks++; if (advance !== 1'b0) begin fails++; $display("FAIL en_adv: got %b want 0", advance); end
    tick();
    checks++; if (acc !== 11'(1)) begin fails++; $display("FAIL en_freeze: got %0d want 1", $signed(acc)); end
    instr = mk(MOV, S_IN, D_ACC, 0); in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL en_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0; clk_en = 1'b1;
  endtask

  task automatic test_reset_wait_out();
    instr = mk(MOV, S_IMM, D_OUT, 17); out_ready = 1'b0; tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rw_pre: valid=%b want 1", out_valid); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || acc !== 11'(0)) begin fails++; $display("FAIL rw_clear: valid=%b acc=%0d want 0/0", out_valid, $signed(acc)); end
    checks++; if (advance !== 1'b0 || in_ready !== 1'b0 || op !== 4'd1 || jmp_off !== 11'(17)) begin fails++; $display("FAIL rw_comb: adv=%b rdy=%b op=%0d off=%0d want 0/0/1/17", advance, in_ready, op, jmp_off); end
    tick();
    reset = 1'b0;
    instr = mk(MOV, S_IMM, D_ACC, 9);
    #1;
    checks++; if (advance !== 1'b1) begin fails++; $display("FAIL rw_resume_adv: got %b want 1", advance); end
    tick();
    checks++; if (acc !== 11'(9) || out_valid !== 1'b0) begin fails++; $display("FAIL rw_resume: acc=%0d valid=%b want 9/0", $signed(acc), out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_in_stall();
    test_out();
    test_sav_neg_swp();
    test_aliases();
    test_clk_en();
    test_reset_wait_out();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
